mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Purpose : arbitrates the MIPS fetch and data ports onto one single-port synchronous memory.
// Latency : grant and memory command are combinational; read data returns exactly one cycle later.
// Backpressure: a requester holds its request until it sees its gnt; loads/stores beat fetch
//               unless fetch has been denied MAX_WAIT cycles in a row.
//
// Ports:
//   mips_clk, mips_rst (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid/if_rdata          : instruction-fetch port
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_gnt,
//      dm_rvalid/dm_rdata                                  : data-memory port
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata, mem_rdata     : shared memory command / read data
//   stall_cnt                                              : total fetch cycles spent waiting
module mips_mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic          mips_clk,
   input  logic          mips_rst,
   // instruction fetch
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   // data memory
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [3:0]    dm_be,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   // shared memory
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // statistics
   output logic [31:0]   stall_cnt
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   // Who owns the read data arriving from memory this cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   owner_t      owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        if_denied;

   always_ff @(posedge mips_clk or negedge mips_rst) begin
      if (!mips_rst) begin
         owner_q     <= OWN_NONE;
         starve_q    <= 4'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      if_gnt      = 1'b0;
      dm_gnt      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_be      = 4'h0;
      mem_addr    = '0;
      mem_wdata   = '0;
      owner_d     = OWN_NONE;
      if_denied   = 1'b0;
      starve_d    = 4'd0;
      stall_cnt_d = stall_cnt_q;

      // Grants are gated by reset so nothing reaches memory while mips_rst is low.
      if (mips_rst) begin
         // A starved fetch overrides the normal data-first priority.
         if (if_req && (!dm_req || starve_q == MAX_W)) begin
            if_gnt = 1'b1;
         end else if (dm_req) begin
            dm_gnt = 1'b1;
         end

         if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
            owner_d  = OWN_IF;
         end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            owner_d   = dm_we ? OWN_NONE : OWN_DM;
         end

         if_denied = if_req && !if_gnt;
         if (if_denied) begin
            starve_d    = (starve_q == MAX_W) ? starve_q : starve_q + 4'd1;
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   assign if_rvalid = (owner_q == OWN_IF);
   assign dm_rvalid = (owner_q == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Purpose : randomized + directed scoreboard bench for mips_mem_arbiter.
// Latency : expected commands checked the cycle they are issued, read data one cycle later.
// Backpressure: bench requesters hold requests until granted, occasionally drop a fetch.
module tb_mips_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAX_WAIT = 3;

   logic          mips_clk = 1'b0;
   logic          mips_rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          dm_req = 1'b0, dm_we = 1'b0;
   logic [3:0]    dm_be = 4'h0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          dm_gnt, dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [31:0]   stall_cnt;

   always #5 mips_clk = ~mips_clk;

   mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .mips_clk(mips_clk), .mips_rst(mips_rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   // Environment: single-port synchronous memory driven by the DUT command.
   logic [31:0] env_mem [16] = '{default: 32'h0};
   always @(posedge mips_clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= env_mem[mem_addr[5:2]];
         end
      end
   end

   // Scoreboard records.
   typedef struct {
      bit          ig, dg, en, we;
      logic [3:0]  be;
      logic [31:0] addr, wdata, stall;
   } cmd_t;
   typedef struct {
      int          due;
      bit          is_if;
      logic [31:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit done = 1'b0;

   // Reference model state.
   logic [31:0] ref_mem [16] = '{default: 32'h0};
   int          starve = 0;
   logic [31:0] exp_stall = 32'h0;

   // Pending requester state.
   bit          p_if = 1'b0, p_dm = 1'b0, p_we = 1'b0;
   logic [31:0] p_if_addr = '0, p_addr = '0, p_wdata = '0;
   logic [3:0]  p_be = 4'h0;
   bit          g_if, g_dm;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive the pending requests for one cycle and record what should happen.
   task automatic apply();
      cmd_t c;
      rsp_t r;
      bit   fw, dw;
      int   idx;
      if_req   = p_if;
      if_addr  = p_if_addr;
      dm_req   = p_dm;
      dm_we    = p_we;
      dm_be    = p_be;
      dm_addr  = p_addr;
      dm_wdata = p_wdata;

      // Data first, unless fetch has waited MAX_WAIT cycles in a row.
      fw = p_if && (!p_dm || starve >= MAX_WAIT);
      dw = p_dm && !fw;
      cyc++;

      c.ig = fw; c.dg = dw; c.en = fw || dw; c.we = 1'b0;
      c.be = 4'h0; c.addr = 32'h0; c.wdata = 32'h0; c.stall = exp_stall;
      if (fw) begin
         c.be = 4'hF; c.addr = p_if_addr;
         r.due = cyc + 1; r.is_if = 1'b1; r.data = ref_mem[p_if_addr[5:2]];
         rsp_q.push_back(r);
      end else if (dw) begin
         c.we = p_we; c.be = p_be; c.addr = p_addr; c.wdata = p_wdata;
         idx = int'(p_addr[5:2]);
         if (p_we) begin
            for (int b = 0; b < 4; b++)
               if (p_be[b]) ref_mem[idx][8*b +: 8] = p_wdata[8*b +: 8];
         end else begin
            r.due = cyc + 1; r.is_if = 1'b0; r.data = ref_mem[idx];
            rsp_q.push_back(r);
         end
      end
      if (p_if && !fw) begin
         starve = (starve + 1 > MAX_WAIT) ? MAX_WAIT : starve + 1;
         exp_stall = exp_stall + 32'd1;
      end else begin
         starve = 0;
      end
      cmd_q.push_back(c);
      g_if = fw;
      g_dm = dw;
      if (fw) p_if = 1'b0;
      if (dw) p_dm = 1'b0;
   endtask

   task automatic new_reqs();
      if (p_if && $urandom_range(15) == 0) p_if = 1'b0;
      if (!p_if && $urandom_range(3) != 0) begin
         p_if = 1'b1;
         p_if_addr = 32'h0040_0000 | (32'($urandom_range(15)) << 2);
      end
      if (!p_dm && $urandom_range(2) != 0) begin
         p_dm = 1'b1;
         p_we = 1'($urandom_range(1));
         p_be = 4'($urandom_range(15));
         p_addr = 32'h1001_0000 | (32'($urandom_range(15)) << 2);
         p_wdata = $urandom;
      end
   endtask

   task automatic set_load(input logic [31:0] a);
      p_dm = 1'b1; p_we = 1'b0; p_be = 4'hF; p_addr = a; p_wdata = 32'h0;
   endtask

   // Monitor: compares the command of the current cycle and the response due now.
   initial begin
      cmd_t c;
      rsp_t r;
      forever begin
         @(negedge mips_clk);
         #2;
         if (mips_rst && !done) begin
            if (cmd_q.size() > 0) begin
               c = cmd_q.pop_front();
               check("if_gnt", 32'(if_gnt), 32'(c.ig));
               check("dm_gnt", 32'(dm_gnt), 32'(c.dg));
               check("mem_en", 32'(mem_en), 32'(c.en));
               check("mem_we", 32'(mem_we), 32'(c.we));
               check("mem_be", 32'(mem_be), 32'(c.be));
               check("mem_addr", mem_addr, c.addr);
               check("mem_wdata", mem_wdata, c.wdata);
               check("stall_cnt", stall_cnt, c.stall);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
               r = rsp_q.pop_front();
               check("if_rvalid", 32'(if_rvalid), 32'(r.is_if));
               check("dm_rvalid", 32'(dm_rvalid), 32'(!r.is_if));
               check("if_rdata", if_rdata, r.is_if ? r.data : 32'h0);
               check("dm_rdata", dm_rdata, r.is_if ? 32'h0 : r.data);
            end else begin
               check("no_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
               check("idle_rdata", if_rdata | dm_rdata, 32'h0);
            end
         end
      end
   end

   // Stimulus.
   initial begin
      logic [7:0] pat;
      pat = 8'b1000_1000;

      // Reset state, with requests asserted to confirm they are gated.
      repeat (2) @(negedge mips_clk);
      if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h0040_0000;
      #1;
      check("rst_if_gnt", 32'(if_gnt), 32'h0);
      check("rst_dm_gnt", 32'(dm_gnt), 32'h0);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
      check("rst_stall", stall_cnt, 32'h0);

      // Fetch only, granted in the first cycle after reset release.
      @(negedge mips_clk);
      mips_rst = 1'b1;
      p_if = 1'b1; p_if_addr = 32'h0040_0000;
      apply();
      #1;
      check("fetch_gnt", 32'(if_gnt), 32'h1);
      check("fetch_addr", mem_addr, 32'h0040_0000);
      @(negedge mips_clk);
      apply();
      #1;
      check("fetch_rvalid", 32'(if_rvalid), 32'h1);

      // Contention: fetch and loads held -> D D D I repeating.
      for (int i = 0; i < 8; i++) begin
         @(negedge mips_clk);
         if (!p_if) begin p_if = 1'b1; p_if_addr = 32'h0040_0000 | (32'(i) << 2); end
         if (!p_dm) set_load(32'h1001_0000 | (32'(i) << 2));
         apply();
         #1;
         check("cont_if_gnt", 32'(if_gnt), 32'(pat[i]));
         check("cont_dm_gnt", 32'(dm_gnt), 32'(!pat[i]));
         if (i == 4) check("cont_stall", stall_cnt, 32'd3);
      end
      p_if = 1'b0; p_dm = 1'b0;
      @(negedge mips_clk);
      apply();

      // Store: byte enables pass through, no response.
      @(negedge mips_clk);
      p_dm = 1'b1; p_we = 1'b1; p_be = 4'b0011; p_addr = 32'h1001_0004; p_wdata = 32'hDEAD_BEEF;
      apply();
      #1;
      check("store_we", 32'(mem_we), 32'h1);
      check("store_be", 32'(mem_be), 32'h3);
      @(negedge mips_clk);
      apply();
      #1;
      check("store_no_rvalid", 32'(dm_rvalid), 32'h0);

      // Interleave: fetch then load.
      @(negedge mips_clk);
      p_if = 1'b1; p_if_addr = 32'h0040_0004;
      apply();
      @(negedge mips_clk);
      set_load(32'h1001_0004);
      apply();
      #1;
      check("ilv_if_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h2);
      @(negedge mips_clk);
      apply();
      #1;
      check("ilv_dm_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h1);
      // Preload the counter just before the edge so it wraps on the next denied fetch.
      #2;
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      exp_stall = 32'hFFFF_FFFF;
      @(negedge mips_clk);
      p_if = 1'b1; p_if_addr = 32'h0040_0008;
      set_load(32'h1001_0008);
      apply();
      @(negedge mips_clk);
      p_if = 1'b0; p_dm = 1'b0;
      apply();
      #1;
      check("stall_wrap", stall_cnt, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         new_reqs();
         @(negedge mips_clk);
         apply();
      end

      // Reset while a load is outstanding.
      p_if = 1'b0;
      @(negedge mips_clk);
      set_load(32'h1001_000C);
      apply();
      #3;
      mips_rst = 1'b0;
      #1;
      check("rmid_dm_rvalid", 32'(dm_rvalid), 32'h0);
      check("rmid_stall", stall_cnt, 32'h0);
      check("rmid_mem_en", 32'(mem_en), 32'h0);
      check("rmid_dm_gnt", 32'(dm_gnt), 32'h0);
      rsp_q.delete();
      cmd_q.delete();
      starve = 0;
      exp_stall = 32'h0;
      p_if = 1'b0; p_dm = 1'b0;
      repeat (2) @(negedge mips_clk);
      mips_rst = 1'b1;
      apply();
      for (int i = 0; i < 100; i++) begin
         new_reqs();
         @(negedge mips_clk);
         apply();
      end

      // Drain.
      p_if = 1'b0; p_dm = 1'b0;
      repeat (2) begin
         @(negedge mips_clk);
         apply();
      end
      #3;
      check("rsp_drain", 32'(rsp_q.size()), 32'h0);
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
